// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the muldiv arbiter block
package muldiv_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter only ever holds LAT-1, so it is sized for the largest legal LAT.
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX);
endpackage

// File: rtl/muldiv_div.sv
// rtl/muldiv_div.sv - combinational unsigned divide, quotient only
module muldiv_div #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q
);
  assign q = a / b;
endmodule

// File: rtl/muldiv_mul.sv
// rtl/muldiv_mul.sv - combinational unsigned multiply, low N bits kept
module muldiv_mul #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/muldiv_rr_arb.sv
// rtl/muldiv_rr_arb.sv - two-way round-robin grant with favour pointer
module muldiv_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  // ptr names the requester that wins a tie; it flips away from whoever was served.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= 1'b0;
    else if (grant != 2'b00) ptr <= ~grant[1];
  end
endmodule

// File: rtl/muldiv_arb.sv
// rtl/muldiv_arb.sv - two-requester shared mul/div unit with fixed latency
// Optional rsp_div0 flag is built when MULDIV_DIV0_FLAG_EN is defined.
module muldiv_arb
  import muldiv_pkg::*;
#(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic         rsp_div0
`endif
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic             id_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [1:0]       grant;
  logic [N-1:0]     mul_p;
  logic [N-1:0]     div_q;
  logic [N-1:0]     result;

  muldiv_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_IDLE),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  muldiv_mul #(.N(N)) u_mul (.a(a_q), .b(b_q), .p(mul_p));
  muldiv_div #(.N(N)) u_div (.a(a_q), .b(b_q), .q(div_q));

  // Divide by zero is pinned to all ones so the result never depends on the divider.
  always_comb begin
    result = mul_p;
    if (op_q == OP_DIV) result = (b_q == '0) ? '1 : div_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= OP_MUL;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
      rsp_div0   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_q  <= grant[1] ? req1_op : req0_op;
            a_q   <= grant[1] ? req1_a  : req0_a;
            b_q   <= grant[1] ? req1_b  : req0_b;
            id_q  <= grant[1];
            cnt   <= CNT_W'(LAT - 1);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= result;
`ifdef MULDIV_DIV0_FLAG_EN
            rsp_div0   <= (op_q == OP_DIV) && (b_q == '0);
`endif
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_arb.sv
// tb/tb_muldiv_arb.sv - directed self-checking bench for muldiv_arb (N=8, LAT=2)
module tb_muldiv_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
`ifdef MULDIV_DIV0_FLAG_EN
  logic       rsp_div0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_arb #(.N(8), .LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .rsp_div0   (rsp_div0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset req0_ready", req0_ready, 0);
    chk("reset req1_ready", req1_ready, 0);
    rst_n = 1'b1;

    // req0 multiply 12*13, response two cycles after accept
    req0_valid = 1; req0_op = 0; req0_a = 8'd12; req0_b = 8'd13;
    #1;
    chk("mul req0_ready", req0_ready, 1);
    chk("mul req1_ready", req1_ready, 0);
    tick();
    req0_a = 8'd1; req0_b = 8'd1;
    #1;
    chk("busy req0_ready", req0_ready, 0);
    chk("busy rsp_valid t0", rsp_valid, 0);
    tick();
    chk("busy rsp_valid t1", rsp_valid, 0);
    req0_valid = 0;
    tick();
    chk("mul rsp_valid", rsp_valid, 1);
    chk("mul rsp_result", rsp_result, 8'h9C);
    chk("mul rsp_id", rsp_id, 0);
    rsp_ready = 1;
    tick();
    chk("mul rsp_valid cleared", rsp_valid, 0);
    rsp_ready = 0;

    // req1 divide 200/7 with consumer stalled; req0 waits with changing operands
    req1_valid = 1; req1_op = 1; req1_a = 8'd200; req1_b = 8'd7;
    #1;
    chk("div req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 0; req0_a = 8'd3; req0_b = 8'd3;
    tick(); tick();
    req0_a = 8'd255; req0_b = 8'd255;
    for (int i = 0; i < 5; i++) begin
      chk("stall rsp_valid", rsp_valid, 1);
      chk("stall rsp_result", rsp_result, 8'd28);
      chk("stall rsp_id", rsp_id, 1);
      chk("stall req0_ready", req0_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("stall release rsp_valid", rsp_valid, 0);
    chk("idle req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick(); tick();
    chk("mul ovf rsp_valid", rsp_valid, 1);
    chk("mul ovf rsp_result", rsp_result, 8'h01);
    chk("mul ovf rsp_id", rsp_id, 0);
    tick();

    // both requesters valid every cycle: last grant was 0, so 1,0,1,0
    req0_valid = 1; req0_op = 0; req0_a = 8'd2; req0_b = 8'd3;
    req1_valid = 1; req1_op = 0; req1_a = 8'd4; req1_b = 8'd5;
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("rr req1_ready", req1_ready, (r % 2 == 0) ? 1 : 0);
      chk("rr req0_ready", req0_ready, (r % 2 == 0) ? 0 : 1);
      tick(); tick(); tick();
      chk("rr rsp_valid", rsp_valid, 1);
      chk("rr rsp_id", rsp_id, (r % 2 == 0) ? 1 : 0);
      chk("rr rsp_result", rsp_result, (r % 2 == 0) ? 8'd20 : 8'd6);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // divide by zero
    req1_valid = 1; req1_op = 1; req1_a = 8'd9; req1_b = 8'd0;
    #1;
    chk("div0 req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick(); tick();
    chk("div0 rsp_valid", rsp_valid, 1);
    chk("div0 rsp_result", rsp_result, 8'hFF);
`ifdef MULDIV_DIV0_FLAG_EN
    chk("div0 flag", rsp_div0, 1);
`endif
    tick();

    // reset during BUSY after a req0 grant left the pointer favouring req1
    req0_valid = 1; req0_op = 0; req0_a = 8'd7; req0_b = 8'd7;
    tick();
    req0_valid = 0;
    rst_n = 0;
    #1;
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort rsp_result", rsp_result, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("abort no rsp", rsp_valid, 0);
      tick();
    end
    req0_valid = 1; req0_op = 0; req0_a = 8'd3; req0_b = 8'd4;
    req1_valid = 1; req1_op = 0; req1_a = 8'd5; req1_b = 8'd5;
    #1;
    chk("post reset req0_ready", req0_ready, 1);
    chk("post reset req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    chk("post reset rsp_valid", rsp_valid, 1);
    chk("post reset rsp_result", rsp_result, 8'd12);
    chk("post reset rsp_id", rsp_id, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
